// File: rtl/fifo_pkg.sv
// Shared types and defaults for the async FIFO, its read-side adapter and their benches.
// Pure declarations: no latency and no backpressure of its own.
package fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_SEQ_START = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fifo_skid_buf2.sv
// 2-entry in-order valid/ready buffer; a push shows on out_valid the next cycle.
// No in_ready: the producer budgets pushes from count so a push never meets a full buffer.
module fifo_skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       cnt;
  logic             pop;

  assign pop       = (cnt != 2'd0) && out_ready;
  assign out_data  = head;
  assign out_valid = (cnt != 2'd0);
  assign count     = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= in_data;
          else             tail <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; the older tail word moves to the head first.
          if (cnt == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read-side adapter: reads when space allows, m_valid 2 cycles after the read, stalls reads on m_ready=0.
// Optional sequence checker under FIFO_RD_SEQ_CHECK_EN.
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int SEQ_START = DEF_SEQ_START
) (
  input  logic             r_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] r_data,
  input  logic             r_empty,
  output logic             destination_r_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt,
  output logic             seq_err,
  output logic [CNT_W-1:0] err_cnt
);

  rd_state_t  state;
  rd_state_t  state_nxt;
  logic       fetch;
  logic       inflight;
  logic [1:0] buf_cnt;
  logic       pop;
  logic [2:0] occupancy;

  // ---------------- state machine ----------------
  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)                              state_nxt = RUN;
        else if (!inflight && (buf_cnt == 2'd0)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fetch = 1'b0;
    busy  = 1'b0;
    case (state)
      IDLE:    begin fetch = 1'b0; busy = 1'b0; end
      RUN:     begin fetch = 1'b1; busy = 1'b1; end
      DRAIN:   begin fetch = 1'b0; busy = 1'b1; end
      default: begin fetch = 1'b0; busy = 1'b0; end
    endcase
  end

  // ---------------- FIFO read issue ----------------
  // Words owned after this edge (buffered + in flight) may never exceed the buffer depth.
  assign pop              = m_valid && m_ready;
  assign occupancy        = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign destination_r_en = fetch && !r_empty && (occupancy < 3'd2);

  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      word_cnt <= '0;
    end else begin
      inflight <= destination_r_en;
      if (inflight) word_cnt <= word_cnt + 1'b1;
    end
  end

  fifo_skid_buf2 #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk       (r_clk),
    .rst       (reset),
    .in_data   (r_data),
    .in_valid  (inflight),
    .out_data  (m_data),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .count     (buf_cnt)
  );

  // ---------------- optional sequence checker ----------------
`ifdef FIFO_RD_SEQ_CHECK_EN
  logic [WIDTH-1:0] expected;
  logic             seq_err_q;
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      expected  <= WIDTH'(SEQ_START);
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      seq_err_q <= 1'b0;
      if (inflight) begin
        if (r_data != expected) begin
          // Resync to the received word so a single gap is reported once, not on every later word.
          seq_err_q <= 1'b1;
          expected  <= r_data + 1'b1;
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        end else begin
          expected <= expected + 1'b1;
        end
      end
    end
  end

  assign seq_err = seq_err_q;
  assign err_cnt = err_cnt_q;
`else
  assign seq_err = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed + randomized bench for fifo_rd_stream_adapter against a queue-based reference model.
module tb_fifo_rd_stream_adapter;
  import fifo_pkg::*;

  localparam int WIDTH     = 8;
  localparam int CNT_W     = 16;
  localparam int SEQ_START = 1;
`ifdef FIFO_RD_SEQ_CHECK_EN
  localparam int SEQ_ON = 1;
`else
  localparam int SEQ_ON = 0;
`endif

  logic             r_clk;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] r_data;
  logic             r_empty;
  logic             destination_r_en;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             busy;
  logic [CNT_W-1:0] word_cnt;
  logic             seq_err;
  logic [CNT_W-1:0] err_cnt;

  fifo_rd_stream_adapter #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .SEQ_START(SEQ_START)
  ) dut (
    .r_clk            (r_clk),
    .reset            (reset),
    .enable           (enable),
    .r_data           (r_data),
    .r_empty          (r_empty),
    .destination_r_en (destination_r_en),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .busy             (busy),
    .word_cnt         (word_cnt),
    .seq_err          (seq_err),
    .err_cnt          (err_cnt)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  // Reference model: FIFO contents, words owned by the adapter with their read cycle, mode, counters.
  logic [7:0] fq[$];
  logic [7:0] pv[$];
  int         pc[$];
  int         cyc_n, mst, m_wc, m_err;
  bit         m_se, prev_rd;
  logic [7:0] prev_val, m_exp, nextv;
  int         n_assert, n_fail, rd_total, dut_rd, dut_se;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fq.push_back(v);
  endtask

  task automatic cyc();
    int         held;
    bit         ev, pe, ed;
    logic [7:0] v;
    r_empty = (fq.size() == 0);
    #1;
    held = pv.size();
    ev   = 1'b0;
    if (held > 0) ev = (cyc_n >= pc[0] + 2);
    pe = ev && m_ready;
    ed = (mst == 1) && !r_empty && ((held - int'(pe)) < 2);
    chk("rd_en", destination_r_en, ed);
    chk("m_valid", m_valid, ev);
    if (ev) chk("m_data", m_data, pv[0]);
    chk("busy", busy, mst != 0);
    chk("word_cnt", word_cnt, 32'(m_wc % 65536));
    chk("seq_err", seq_err, m_se);
    chk("err_cnt", err_cnt, m_err);
    dut_rd += int'(destination_r_en && !r_empty);
    dut_se += int'(seq_err);
    v = 8'h00;
    if (ed) begin
      v = fq.pop_front();
      pv.push_back(v);
      pc.push_back(cyc_n);
      rd_total++;
    end
    if (pe) begin
      void'(pv.pop_front());
      void'(pc.pop_front());
    end
    @(posedge r_clk);
    m_se = 1'b0;
    if (prev_rd) begin
      m_wc++;
`ifdef FIFO_RD_SEQ_CHECK_EN
      if (prev_val != m_exp) begin
        m_se  = 1'b1;
        m_exp = prev_val + 8'd1;
        if (m_err < 65535) m_err++;
      end else begin
        m_exp = m_exp + 8'd1;
      end
`endif
    end
    case (mst)
      0: if (enable) mst = 1;
      1: if (!enable) mst = 2;
      default: begin
        if (enable)         mst = 1;
        else if (held == 0) mst = 0;
      end
    endcase
    prev_rd  = ed;
    prev_val = v;
    cyc_n++;
    @(negedge r_clk);
    r_data = ed ? v : 8'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((fq.size() != 0 || pv.size() != 0) && k < limit) begin
      cyc();
      k++;
    end
    chk("drain_left", fq.size() + pv.size(), 0);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while ((pv.size() != 0 || mst != 0) && k < limit) begin
      cyc();
      k++;
    end
    chk("idle_left", pv.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_rd_en", destination_r_en, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    pv.delete();
    pc.delete();
    mst     = 0;
    m_wc    = 0;
    m_err   = 0;
    m_se    = 1'b0;
    m_exp   = 8'(SEQ_START);
    prev_rd = 1'b0;
    @(posedge r_clk);
    @(negedge r_clk);
    reset  = 1'b0;
    r_data = 8'($urandom);
  endtask

  initial begin
    int r0, s0;
    reset = 1'b1; enable = 1'b0; m_ready = 1'b0; r_data = '0; r_empty = 1'b1;
    n_assert = 0; n_fail = 0; rd_total = 0; dut_rd = 0; dut_se = 0; cyc_n = 0;
    do_reset();
    run(2);

    // Preloaded 1..8 streamed at full rate.
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    nextv = 8'd9;
    run(14);
    chk("p1_word_cnt", word_cnt, 8);
    chk("p1_err_cnt", err_cnt, 0);

    // Downstream stalled: only two reads may be outstanding.
    m_ready = 1'b0; r0 = dut_rd;
    for (int i = 0; i < 8; i++) begin push(nextv); nextv = nextv + 8'd1; end
    run(6);
    chk("p2_reads", dut_rd - r0, 2);
    m_ready = 1'b1;
    drain(40);

    // Enable dropped during the third read.
    r0 = dut_rd;
    for (int i = 0; i < 10; i++) begin push(nextv); nextv = nextv + 8'd1; end
    for (int k = 0; k < 10 && (dut_rd - r0) < 2; k++) cyc();
    enable = 1'b0;
    wait_idle(20);
    chk("p3_reads", dut_rd - r0, 3);
    chk("p3_busy", busy, 0);
    enable = 1'b1;
    drain(40);

    // Gap in the sequence: n, n+1, n+3, n+4.
    s0 = dut_se;
    push(nextv); push(nextv + 8'd1); push(nextv + 8'd3); push(nextv + 8'd4);
    nextv = nextv + 8'd5;
    drain(20);
    run(2);
    chk("p4_seq_pulses", dut_se - s0, SEQ_ON);
    chk("p4_err_cnt", err_cnt, SEQ_ON);

    // Continuous run through 0xFE, 0xFF, 0x00 wrap.
    s0 = dut_se;
    while (nextv != 8'h02) begin push(nextv); nextv = nextv + 8'd1; end
    drain(400);
    run(2);
    chk("p5_wrap_pulses", dut_se - s0, 0);
    chk("p5_err_cnt", err_cnt, SEQ_ON);

    // Reset with words buffered and in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin push(nextv); nextv = nextv + 8'd1; end
    run(3);
    do_reset();
    m_ready = 1'b1;
    drain(20);
    run(2);
    chk("p6_word_cnt", word_cnt, 2);

    // Randomized traffic with gaps, stalls, enable toggles and one reset.
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 3) == 0 && fq.size() < 6) begin
        if (($urandom % 12) == 0) nextv = nextv + 8'd2;
        push(nextv);
        nextv = nextv + 8'd1;
      end
      m_ready = (($urandom % 4) != 0);
      if (($urandom % 25) == 0) enable = ~enable;
      if (i == 200) do_reset();
      cyc();
    end
    enable = 1'b1; m_ready = 1'b1;
    drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
